// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter. Read and write paths arbitrate independently
// (round-robin, one outstanding transaction each); responses follow the registered grant.
module axi_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  // master s0
  input  logic                      io_s0_aw_valid,
  input  logic [ID_WIDTH-1:0]       io_s0_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0]     io_s0_aw_bits_addr,
  input  logic [7:0]                io_s0_aw_bits_len,
  input  logic [2:0]                io_s0_aw_bits_size,
  input  logic [1:0]                io_s0_aw_bits_burst,
  output logic                      io_s0_aw_ready,
  input  logic                      io_s0_w_valid,
  input  logic [DATA_WIDTH-1:0]     io_s0_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0]   io_s0_w_bits_strb,
  input  logic                      io_s0_w_bits_last,
  output logic                      io_s0_w_ready,
  output logic                      io_s0_b_valid,
  output logic [ID_WIDTH-1:0]       io_s0_b_bits_id,
  output logic [1:0]                io_s0_b_bits_resp,
  input  logic                      io_s0_b_ready,
  input  logic                      io_s0_ar_valid,
  input  logic [ID_WIDTH-1:0]       io_s0_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0]     io_s0_ar_bits_addr,
  input  logic [7:0]                io_s0_ar_bits_len,
  input  logic [2:0]                io_s0_ar_bits_size,
  input  logic [1:0]                io_s0_ar_bits_burst,
  output logic                      io_s0_ar_ready,
  output logic                      io_s0_r_valid,
  output logic [ID_WIDTH-1:0]       io_s0_r_bits_id,
  output logic [DATA_WIDTH-1:0]     io_s0_r_bits_data,
  output logic [1:0]                io_s0_r_bits_resp,
  output logic                      io_s0_r_bits_last,
  input  logic                      io_s0_r_ready,
  // master s1
  input  logic                      io_s1_aw_valid,
  input  logic [ID_WIDTH-1:0]       io_s1_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0]     io_s1_aw_bits_addr,
  input  logic [7:0]                io_s1_aw_bits_len,
  input  logic [2:0]                io_s1_aw_bits_size,
  input  logic [1:0]                io_s1_aw_bits_burst,
  output logic                      io_s1_aw_ready,
  input  logic                      io_s1_w_valid,
  input  logic [DATA_WIDTH-1:0]     io_s1_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0]   io_s1_w_bits_strb,
  input  logic                      io_s1_w_bits_last,
  output logic                      io_s1_w_ready,
  output logic                      io_s1_b_valid,
  output logic [ID_WIDTH-1:0]       io_s1_b_bits_id,
  output logic [1:0]                io_s1_b_bits_resp,
  input  logic                      io_s1_b_ready,
  input  logic                      io_s1_ar_valid,
  input  logic [ID_WIDTH-1:0]       io_s1_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0]     io_s1_ar_bits_addr,
  input  logic [7:0]                io_s1_ar_bits_len,
  input  logic [2:0]                io_s1_ar_bits_size,
  input  logic [1:0]                io_s1_ar_bits_burst,
  output logic                      io_s1_ar_ready,
  output logic                      io_s1_r_valid,
  output logic [ID_WIDTH-1:0]       io_s1_r_bits_id,
  output logic [DATA_WIDTH-1:0]     io_s1_r_bits_data,
  output logic [1:0]                io_s1_r_bits_resp,
  output logic                      io_s1_r_bits_last,
  input  logic                      io_s1_r_ready,
  // downstream slave port
  output logic                      io_m_aw_valid,
  output logic [ID_WIDTH:0]         io_m_aw_bits_id,
  output logic [ADDR_WIDTH-1:0]     io_m_aw_bits_addr,
  output logic [7:0]                io_m_aw_bits_len,
  output logic [2:0]                io_m_aw_bits_size,
  output logic [1:0]                io_m_aw_bits_burst,
  input  logic                      io_m_aw_ready,
  output logic                      io_m_w_valid,
  output logic [DATA_WIDTH-1:0]     io_m_w_bits_data,
  output logic [DATA_WIDTH/8-1:0]   io_m_w_bits_strb,
  output logic                      io_m_w_bits_last,
  input  logic                      io_m_w_ready,
  input  logic                      io_m_b_valid,
  input  logic [ID_WIDTH:0]         io_m_b_bits_id,
  input  logic [1:0]                io_m_b_bits_resp,
  output logic                      io_m_b_ready,
  output logic                      io_m_ar_valid,
  output logic [ID_WIDTH:0]         io_m_ar_bits_id,
  output logic [ADDR_WIDTH-1:0]     io_m_ar_bits_addr,
  output logic [7:0]                io_m_ar_bits_len,
  output logic [2:0]                io_m_ar_bits_size,
  output logic [1:0]                io_m_ar_bits_burst,
  input  logic                      io_m_ar_ready,
  input  logic                      io_m_r_valid,
  input  logic [ID_WIDTH:0]         io_m_r_bits_id,
  input  logic [DATA_WIDTH-1:0]     io_m_r_bits_data,
  input  logic [1:0]                io_m_r_bits_resp,
  input  logic                      io_m_r_bits_last,
  output logic                      io_m_r_ready,
  // FSM state observation
  output logic [1:0]                dbg_w_state,
  output logic [1:0]                dbg_r_state
);

  // Handshake rule on every channel: a transfer happens in a cycle where valid and
  // ready are both 1 at the rising clock edge; valid never waits on ready.

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_BUSY = 2'd1, W_RESP = 2'd2} w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;
  logic     rgnt, rgnt_nxt, rptr, rptr_nxt;
  logic     wgnt, wgnt_nxt, wptr, wptr_nxt;
  logic     aw_done, aw_done_nxt, w_done, w_done_nxt;

  logic     sel_ar_valid, sel_aw_valid, sel_w_valid, sel_w_last;
  logic     sel_r_ready, sel_b_ready;
  logic     unused_resp_id_msb;

  assign dbg_r_state = r_state;
  assign dbg_w_state = w_state;

  // Response routing uses the registered grant, never the returned id MSB.
  assign unused_resp_id_msb = io_m_r_bits_id[ID_WIDTH] ^ io_m_b_bits_id[ID_WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rgnt    <= 1'b0;
      rptr    <= 1'b0;
      w_state <= W_IDLE;
      wgnt    <= 1'b0;
      wptr    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      rgnt    <= rgnt_nxt;
      rptr    <= rptr_nxt;
      w_state <= w_state_nxt;
      wgnt    <= wgnt_nxt;
      wptr    <= wptr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Payload muxes are always driven from the granted master (grant 0 selects s0).
  assign io_m_ar_bits_id    = {rgnt, rgnt ? io_s1_ar_bits_id : io_s0_ar_bits_id};
  assign io_m_ar_bits_addr  = rgnt ? io_s1_ar_bits_addr  : io_s0_ar_bits_addr;
  assign io_m_ar_bits_len   = rgnt ? io_s1_ar_bits_len   : io_s0_ar_bits_len;
  assign io_m_ar_bits_size  = rgnt ? io_s1_ar_bits_size  : io_s0_ar_bits_size;
  assign io_m_ar_bits_burst = rgnt ? io_s1_ar_bits_burst : io_s0_ar_bits_burst;

  assign io_m_aw_bits_id    = {wgnt, wgnt ? io_s1_aw_bits_id : io_s0_aw_bits_id};
  assign io_m_aw_bits_addr  = wgnt ? io_s1_aw_bits_addr  : io_s0_aw_bits_addr;
  assign io_m_aw_bits_len   = wgnt ? io_s1_aw_bits_len   : io_s0_aw_bits_len;
  assign io_m_aw_bits_size  = wgnt ? io_s1_aw_bits_size  : io_s0_aw_bits_size;
  assign io_m_aw_bits_burst = wgnt ? io_s1_aw_bits_burst : io_s0_aw_bits_burst;
  assign io_m_w_bits_data   = wgnt ? io_s1_w_bits_data   : io_s0_w_bits_data;
  assign io_m_w_bits_strb   = wgnt ? io_s1_w_bits_strb   : io_s0_w_bits_strb;
  assign io_m_w_bits_last   = wgnt ? io_s1_w_bits_last   : io_s0_w_bits_last;

  assign io_s0_r_bits_id    = io_m_r_bits_id[ID_WIDTH-1:0];
  assign io_s1_r_bits_id    = io_m_r_bits_id[ID_WIDTH-1:0];
  assign io_s0_r_bits_data  = io_m_r_bits_data;
  assign io_s1_r_bits_data  = io_m_r_bits_data;
  assign io_s0_r_bits_resp  = io_m_r_bits_resp;
  assign io_s1_r_bits_resp  = io_m_r_bits_resp;
  assign io_s0_r_bits_last  = io_m_r_bits_last;
  assign io_s1_r_bits_last  = io_m_r_bits_last;
  assign io_s0_b_bits_id    = io_m_b_bits_id[ID_WIDTH-1:0];
  assign io_s1_b_bits_id    = io_m_b_bits_id[ID_WIDTH-1:0];
  assign io_s0_b_bits_resp  = io_m_b_bits_resp;
  assign io_s1_b_bits_resp  = io_m_b_bits_resp;

  assign sel_ar_valid = rgnt ? io_s1_ar_valid : io_s0_ar_valid;
  assign sel_r_ready  = rgnt ? io_s1_r_ready  : io_s0_r_ready;
  assign sel_aw_valid = wgnt ? io_s1_aw_valid : io_s0_aw_valid;
  assign sel_w_valid  = wgnt ? io_s1_w_valid  : io_s0_w_valid;
  assign sel_w_last   = wgnt ? io_s1_w_bits_last : io_s0_w_bits_last;
  assign sel_b_ready  = wgnt ? io_s1_b_ready  : io_s0_b_ready;

  // Read path
  always_comb begin
    r_state_nxt    = r_state;
    rgnt_nxt       = rgnt;
    rptr_nxt       = rptr;
    io_m_ar_valid  = 1'b0;
    io_s0_ar_ready = 1'b0;
    io_s1_ar_ready = 1'b0;
    io_s0_r_valid  = 1'b0;
    io_s1_r_valid  = 1'b0;
    io_m_r_ready   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (io_s0_ar_valid || io_s1_ar_valid) begin
          rgnt_nxt    = (io_s0_ar_valid && io_s1_ar_valid) ? rptr : io_s1_ar_valid;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        io_m_ar_valid  = sel_ar_valid;
        io_s0_ar_ready = !rgnt && io_m_ar_ready;
        io_s1_ar_ready = rgnt && io_m_ar_ready;
        if (sel_ar_valid && io_m_ar_ready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        io_s0_r_valid = !rgnt && io_m_r_valid;
        io_s1_r_valid = rgnt && io_m_r_valid;
        io_m_r_ready  = sel_r_ready;
        if (io_m_r_valid && sel_r_ready && io_m_r_bits_last) begin
          r_state_nxt = R_IDLE;
          rptr_nxt    = ~rgnt;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write path: AW and the W burst complete independently; both flags gate entry to W_RESP.
  always_comb begin
    w_state_nxt    = w_state;
    wgnt_nxt       = wgnt;
    wptr_nxt       = wptr;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;
    io_m_aw_valid  = 1'b0;
    io_s0_aw_ready = 1'b0;
    io_s1_aw_ready = 1'b0;
    io_m_w_valid   = 1'b0;
    io_s0_w_ready  = 1'b0;
    io_s1_w_ready  = 1'b0;
    io_s0_b_valid  = 1'b0;
    io_s1_b_valid  = 1'b0;
    io_m_b_ready   = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (io_s0_aw_valid || io_s1_aw_valid) begin
          wgnt_nxt    = (io_s0_aw_valid && io_s1_aw_valid) ? wptr : io_s1_aw_valid;
          w_state_nxt = W_BUSY;
        end
      end
      W_BUSY: begin
        io_m_aw_valid  = sel_aw_valid && !aw_done;
        io_s0_aw_ready = !wgnt && io_m_aw_ready && !aw_done;
        io_s1_aw_ready = wgnt && io_m_aw_ready && !aw_done;
        io_m_w_valid   = sel_w_valid && !w_done;
        io_s0_w_ready  = !wgnt && io_m_w_ready && !w_done;
        io_s1_w_ready  = wgnt && io_m_w_ready && !w_done;
        if (sel_aw_valid && io_m_aw_ready && !aw_done) aw_done_nxt = 1'b1;
        if (sel_w_valid && io_m_w_ready && !w_done && sel_w_last) w_done_nxt = 1'b1;
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        io_s0_b_valid = !wgnt && io_m_b_valid;
        io_s1_b_valid = wgnt && io_m_b_valid;
        io_m_b_ready  = sel_b_ready;
        if (io_m_b_valid && sel_b_ready) begin
          w_state_nxt = W_IDLE;
          wptr_nxt    = ~wgnt;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed bench for axi_arbiter_2to1: a table of single transactions plus hand-written
// sequences for arbitration order, burst blocking, W-before-AW, path independence and reset.
module tb_axi_arbiter_2to1;

  logic        clock, reset;
  logic        s0_aw_valid, s0_aw_ready, s0_w_valid, s0_w_last, s0_w_ready;
  logic [3:0]  s0_aw_id, s0_w_strb, s0_b_id, s0_ar_id, s0_r_id;
  logic [31:0] s0_aw_addr, s0_w_data, s0_ar_addr, s0_r_data;
  logic [7:0]  s0_aw_len, s0_ar_len;
  logic [2:0]  s0_aw_size, s0_ar_size;
  logic [1:0]  s0_aw_burst, s0_ar_burst, s0_b_resp, s0_r_resp;
  logic        s0_b_valid, s0_b_ready, s0_ar_valid, s0_ar_ready;
  logic        s0_r_valid, s0_r_last, s0_r_ready;
  logic        s1_aw_valid, s1_aw_ready, s1_w_valid, s1_w_last, s1_w_ready;
  logic [3:0]  s1_aw_id, s1_w_strb, s1_b_id, s1_ar_id, s1_r_id;
  logic [31:0] s1_aw_addr, s1_w_data, s1_ar_addr, s1_r_data;
  logic [7:0]  s1_aw_len, s1_ar_len;
  logic [2:0]  s1_aw_size, s1_ar_size;
  logic [1:0]  s1_aw_burst, s1_ar_burst, s1_b_resp, s1_r_resp;
  logic        s1_b_valid, s1_b_ready, s1_ar_valid, s1_ar_ready;
  logic        s1_r_valid, s1_r_last, s1_r_ready;
  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_last, m_w_ready;
  logic [4:0]  m_aw_id, m_b_id, m_ar_id, m_r_id;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic [3:0]  m_w_strb;
  logic [7:0]  m_aw_len, m_ar_len;
  logic [2:0]  m_aw_size, m_ar_size;
  logic [1:0]  m_aw_burst, m_ar_burst, m_b_resp, m_r_resp;
  logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready;
  logic        m_r_valid, m_r_last, m_r_ready;
  logic [1:0]  dbg_w_state, dbg_r_state;

  int n_checks = 0;
  int n_errors = 0;

  axi_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .io_s0_aw_valid(s0_aw_valid), .io_s0_aw_bits_id(s0_aw_id), .io_s0_aw_bits_addr(s0_aw_addr),
    .io_s0_aw_bits_len(s0_aw_len), .io_s0_aw_bits_size(s0_aw_size), .io_s0_aw_bits_burst(s0_aw_burst),
    .io_s0_aw_ready(s0_aw_ready),
    .io_s0_w_valid(s0_w_valid), .io_s0_w_bits_data(s0_w_data), .io_s0_w_bits_strb(s0_w_strb),
    .io_s0_w_bits_last(s0_w_last), .io_s0_w_ready(s0_w_ready),
    .io_s0_b_valid(s0_b_valid), .io_s0_b_bits_id(s0_b_id), .io_s0_b_bits_resp(s0_b_resp),
    .io_s0_b_ready(s0_b_ready),
    .io_s0_ar_valid(s0_ar_valid), .io_s0_ar_bits_id(s0_ar_id), .io_s0_ar_bits_addr(s0_ar_addr),
    .io_s0_ar_bits_len(s0_ar_len), .io_s0_ar_bits_size(s0_ar_size), .io_s0_ar_bits_burst(s0_ar_burst),
    .io_s0_ar_ready(s0_ar_ready),
    .io_s0_r_valid(s0_r_valid), .io_s0_r_bits_id(s0_r_id), .io_s0_r_bits_data(s0_r_data),
    .io_s0_r_bits_resp(s0_r_resp), .io_s0_r_bits_last(s0_r_last), .io_s0_r_ready(s0_r_ready),
    .io_s1_aw_valid(s1_aw_valid), .io_s1_aw_bits_id(s1_aw_id), .io_s1_aw_bits_addr(s1_aw_addr),
    .io_s1_aw_bits_len(s1_aw_len), .io_s1_aw_bits_size(s1_aw_size), .io_s1_aw_bits_burst(s1_aw_burst),
    .io_s1_aw_ready(s1_aw_ready),
    .io_s1_w_valid(s1_w_valid), .io_s1_w_bits_data(s1_w_data), .io_s1_w_bits_strb(s1_w_strb),
    .io_s1_w_bits_last(s1_w_last), .io_s1_w_ready(s1_w_ready),
    .io_s1_b_valid(s1_b_valid), .io_s1_b_bits_id(s1_b_id), .io_s1_b_bits_resp(s1_b_resp),
    .io_s1_b_ready(s1_b_ready),
    .io_s1_ar_valid(s1_ar_valid), .io_s1_ar_bits_id(s1_ar_id), .io_s1_ar_bits_addr(s1_ar_addr),
    .io_s1_ar_bits_len(s1_ar_len), .io_s1_ar_bits_size(s1_ar_size), .io_s1_ar_bits_burst(s1_ar_burst),
    .io_s1_ar_ready(s1_ar_ready),
    .io_s1_r_valid(s1_r_valid), .io_s1_r_bits_id(s1_r_id), .io_s1_r_bits_data(s1_r_data),
    .io_s1_r_bits_resp(s1_r_resp), .io_s1_r_bits_last(s1_r_last), .io_s1_r_ready(s1_r_ready),
    .io_m_aw_valid(m_aw_valid), .io_m_aw_bits_id(m_aw_id), .io_m_aw_bits_addr(m_aw_addr),
    .io_m_aw_bits_len(m_aw_len), .io_m_aw_bits_size(m_aw_size), .io_m_aw_bits_burst(m_aw_burst),
    .io_m_aw_ready(m_aw_ready),
    .io_m_w_valid(m_w_valid), .io_m_w_bits_data(m_w_data), .io_m_w_bits_strb(m_w_strb),
    .io_m_w_bits_last(m_w_last), .io_m_w_ready(m_w_ready),
    .io_m_b_valid(m_b_valid), .io_m_b_bits_id(m_b_id), .io_m_b_bits_resp(m_b_resp),
    .io_m_b_ready(m_b_ready),
    .io_m_ar_valid(m_ar_valid), .io_m_ar_bits_id(m_ar_id), .io_m_ar_bits_addr(m_ar_addr),
    .io_m_ar_bits_len(m_ar_len), .io_m_ar_bits_size(m_ar_size), .io_m_ar_bits_burst(m_ar_burst),
    .io_m_ar_ready(m_ar_ready),
    .io_m_r_valid(m_r_valid), .io_m_r_bits_id(m_r_id), .io_m_r_bits_data(m_r_data),
    .io_m_r_bits_resp(m_r_resp), .io_m_r_bits_last(m_r_last), .io_m_r_ready(m_r_ready),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input logic src, input logic a0, input logic a1);
    return src ? a1 : a0;
  endfunction

  function automatic logic [31:0] pick32(input logic src, input logic [31:0] a0, input logic [31:0] a1);
    return src ? a1 : a0;
  endfunction

  function automatic logic any_vr();
    return s0_aw_ready | s0_w_ready | s0_b_valid | s0_ar_ready | s0_r_valid |
           s1_aw_ready | s1_w_ready | s1_b_valid | s1_ar_ready | s1_r_valid |
           m_aw_valid | m_w_valid | m_b_ready | m_ar_valid | m_r_ready;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    {s0_aw_valid, s0_w_valid, s0_ar_valid, s1_aw_valid, s1_w_valid, s1_ar_valid} = '0;
    {s0_aw_id, s0_ar_id, s1_aw_id, s1_ar_id} = '0;
    {s0_aw_addr, s0_ar_addr, s1_aw_addr, s1_ar_addr, s0_w_data, s1_w_data} = '0;
    {s0_aw_len, s0_ar_len, s1_aw_len, s1_ar_len} = '0;
    s0_aw_size = 3'd2; s0_ar_size = 3'd2; s1_aw_size = 3'd2; s1_ar_size = 3'd2;
    s0_aw_burst = 2'd1; s0_ar_burst = 2'd1; s1_aw_burst = 2'd1; s1_ar_burst = 2'd1;
    {s0_w_strb, s1_w_strb, s0_w_last, s1_w_last} = '0;
    {s0_b_ready, s0_r_ready, s1_b_ready, s1_r_ready} = 4'hF;
    {m_aw_ready, m_w_ready, m_ar_ready, m_b_valid, m_r_valid, m_r_last} = '0;
    {m_b_id, m_r_id, m_b_resp, m_r_resp, m_r_data} = '0;
  endtask

  task automatic drive_ar(input logic src, input logic v, input logic [3:0] id,
                          input logic [31:0] addr, input logic [7:0] len);
    if (src) begin s1_ar_valid = v; s1_ar_id = id; s1_ar_addr = addr; s1_ar_len = len; end
    else     begin s0_ar_valid = v; s0_ar_id = id; s0_ar_addr = addr; s0_ar_len = len; end
  endtask

  task automatic drive_aw(input logic src, input logic v, input logic [3:0] id, input logic [31:0] addr);
    if (src) begin s1_aw_valid = v; s1_aw_id = id; s1_aw_addr = addr; end
    else     begin s0_aw_valid = v; s0_aw_id = id; s0_aw_addr = addr; end
  endtask

  task automatic drive_w(input logic src, input logic v, input logic [31:0] data, input logic [3:0] strb);
    if (src) begin s1_w_valid = v; s1_w_data = data; s1_w_strb = strb; s1_w_last = v; end
    else     begin s0_w_valid = v; s0_w_data = data; s0_w_strb = strb; s0_w_last = v; end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // ---------------- transaction table ----------------
  typedef struct {
    logic        is_wr;
    logic        src;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [4:0]  slv_id;   // id the slave model returns on r/b
    logic [1:0]  resp;
    logic [4:0]  exp_mid;  // required downstream id
  } vec_t;

  vec_t vecs[6];

  // All tasks start and end 1 time unit after a rising edge with both FSMs idle.
  task automatic run_read(input vec_t v);
    drive_ar(v.src, 1'b1, v.id, v.addr, v.len);
    m_ar_ready = 1'b1;
    #1 check("rd_idle_ar_ready", pick(v.src, s0_ar_ready, s1_ar_ready), 1'b0);
    check("rd_idle_m_ar_valid", m_ar_valid, 1'b0);
    @(posedge clock); #1;
    check("rd_m_ar_valid", m_ar_valid, 1'b1);
    check("rd_m_ar_id", m_ar_id, v.exp_mid);
    check("rd_m_ar_addr", m_ar_addr, v.addr);
    check("rd_m_ar_len", m_ar_len, v.len);
    check("rd_own_ar_ready", pick(v.src, s0_ar_ready, s1_ar_ready), 1'b1);
    check("rd_other_ar_ready", pick(v.src, s1_ar_ready, s0_ar_ready), 1'b0);
    @(posedge clock); #1;
    drive_ar(v.src, 1'b0, 4'h0, 32'h0, 8'h0);
    m_ar_ready = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      m_r_valid = 1'b1; m_r_id = v.slv_id; m_r_data = v.data + i;
      m_r_resp = v.resp; m_r_last = (i == int'(v.len));
      #1;
      check("rd_own_r_valid", pick(v.src, s0_r_valid, s1_r_valid), 1'b1);
      check("rd_other_r_valid", pick(v.src, s1_r_valid, s0_r_valid), 1'b0);
      check("rd_r_data", pick32(v.src, s0_r_data, s1_r_data), v.data + i);
      check("rd_r_id", v.src ? s1_r_id : s0_r_id, v.id);
      check("rd_r_resp", v.src ? s1_r_resp : s0_r_resp, v.resp);
      check("rd_m_r_ready", m_r_ready, 1'b1);
      @(posedge clock); #1;
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
  endtask

  // AW handshakes first, W one cycle later, then the b response.
  task automatic run_write(input vec_t v);
    drive_aw(v.src, 1'b1, v.id, v.addr);
    drive_w(v.src, 1'b1, v.data, v.strb);
    m_aw_ready = 1'b1; m_w_ready = 1'b0;
    #1 check("wr_idle_aw_ready", pick(v.src, s0_aw_ready, s1_aw_ready), 1'b0);
    @(posedge clock); #1;
    check("wr_m_aw_valid", m_aw_valid, 1'b1);
    check("wr_m_aw_id", m_aw_id, v.exp_mid);
    check("wr_m_aw_addr", m_aw_addr, v.addr);
    check("wr_own_aw_ready", pick(v.src, s0_aw_ready, s1_aw_ready), 1'b1);
    check("wr_other_aw_ready", pick(v.src, s1_aw_ready, s0_aw_ready), 1'b0);
    check("wr_m_w_valid", m_w_valid, 1'b1);
    check("wr_m_w_data", m_w_data, v.data);
    check("wr_m_w_strb", m_w_strb, v.strb);
    check("wr_own_w_ready_held", pick(v.src, s0_w_ready, s1_w_ready), 1'b0);
    @(posedge clock); #1;
    drive_aw(v.src, 1'b0, 4'h0, 32'h0);
    m_aw_ready = 1'b0; m_w_ready = 1'b1;
    #1 check("wr_m_aw_valid_done", m_aw_valid, 1'b0);
    check("wr_own_w_ready", pick(v.src, s0_w_ready, s1_w_ready), 1'b1);
    check("wr_dbg_busy", dbg_w_state, 2'd1);
    @(posedge clock); #1;
    drive_w(v.src, 1'b0, 32'h0, 4'h0);
    m_w_ready = 1'b0;
    m_b_valid = 1'b1; m_b_id = v.slv_id; m_b_resp = v.resp;
    #1 check("wr_own_b_valid", pick(v.src, s0_b_valid, s1_b_valid), 1'b1);
    check("wr_other_b_valid", pick(v.src, s1_b_valid, s0_b_valid), 1'b0);
    check("wr_b_id", v.src ? s1_b_id : s0_b_id, v.id);
    check("wr_b_resp", v.src ? s1_b_resp : s0_b_resp, v.resp);
    check("wr_m_b_ready", m_b_ready, 1'b1);
    @(posedge clock); #1;
    m_b_valid = 1'b0;
    #1 check("wr_back_idle", dbg_w_state, 2'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // is_wr src id addr len data strb slv_id resp exp_mid
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0800_0000, 8'd0, 32'hDEAD_BEEF, 4'h0, 5'h00, 2'd0, 5'h00};
    vecs[1] = '{1'b0, 1'b1, 4'h1, 32'h0800_0004, 8'd1, 32'hA5A5_0000, 4'h0, 5'h11, 2'd0, 5'h11};
    vecs[2] = '{1'b0, 1'b1, 4'hF, 32'h1000_00F0, 8'd0, 32'h1234_5678, 4'h0, 5'h0F, 2'd0, 5'h1F};
    vecs[3] = '{1'b1, 1'b0, 4'hA, 32'h2000_0000, 8'd0, 32'hCAFE_F00D, 4'h3, 5'h0A, 2'd2, 5'h0A};
    vecs[4] = '{1'b1, 1'b1, 4'h3, 32'h2000_0010, 8'd0, 32'h0BAD_C0DE, 4'hF, 5'h03, 2'd0, 5'h13};
    vecs[5] = '{1'b0, 1'b0, 4'h5, 32'h3000_0040, 8'd2, 32'h0000_1000, 4'h0, 5'h05, 2'd3, 5'h05};

    clear_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    s0_ar_valid = 1'b1; s1_aw_valid = 1'b1; m_r_valid = 1'b1; m_b_valid = 1'b1;
    #2 check("reset_all_vr", any_vr(), 1'b0);
    check("reset_dbg", {dbg_w_state, dbg_r_state}, 4'h0);
    @(posedge clock); #1;
    check("reset_held_all_vr", any_vr(), 1'b0);
    apply_reset();

    // table: single reads/writes including test-plan single read
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) run_write(vecs[i]);
      else               run_read(vecs[i]);
    end

    // simultaneous reads: s0 first, then s1, then s0 wins again
    apply_reset();
    drive_ar(1'b0, 1'b1, 4'h0, 32'h0800_0000, 8'd0);
    drive_ar(1'b1, 1'b1, 4'h1, 32'h0800_0004, 8'd0);
    m_ar_ready = 1'b1;
    @(posedge clock); #1;
    check("sim_first_id", m_ar_id, 5'h00);
    check("sim_first_addr", m_ar_addr, 32'h0800_0000);
    check("sim_s1_ar_ready_lose", s1_ar_ready, 1'b0);
    @(posedge clock); #1;
    drive_ar(1'b0, 1'b0, 4'h0, 32'h0, 8'd0);
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 32'h1111_1111; m_r_id = 5'h00;
    #1 check("sim_s0_r_valid", s0_r_valid, 1'b1);
    check("sim_s1_r_valid", s1_r_valid, 1'b0);
    check("sim_s1_ar_ready_data", s1_ar_ready, 1'b0);
    @(posedge clock); #1;
    m_r_valid = 1'b0;
    #1 check("sim_idle_gap", m_ar_valid, 1'b0);
    @(posedge clock); #1;
    check("sim_second_valid", m_ar_valid, 1'b1);
    check("sim_second_id", m_ar_id, 5'h11);
    check("sim_second_addr", m_ar_addr, 32'h0800_0004);
    check("sim_s1_ar_ready", s1_ar_ready, 1'b1);
    @(posedge clock); #1;
    drive_ar(1'b1, 1'b0, 4'h0, 32'h0, 8'd0);
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 32'h2222_2222; m_r_id = 5'h11;
    #1 check("sim_s1_r_data", s1_r_data, 32'h2222_2222);
    check("sim_s1_r_id", s1_r_id, 4'h1);
    check("sim_s0_r_valid_off", s0_r_valid, 1'b0);
    @(posedge clock); #1;
    m_r_valid = 1'b0;
    drive_ar(1'b0, 1'b1, 4'h0, 32'h0800_0000, 8'd0);
    drive_ar(1'b1, 1'b1, 4'h1, 32'h0800_0004, 8'd0);
    @(posedge clock); #1;
    check("sim_repeat_id", m_ar_id, 5'h00);
    check("sim_repeat_s0_ready", s0_ar_ready, 1'b1);

    // burst blocking: s1 waits through s0's 4-beat burst
    apply_reset();
    drive_ar(1'b0, 1'b1, 4'h2, 32'h0800_0100, 8'd3);
    m_ar_ready = 1'b1;
    @(posedge clock); #1;
    drive_ar(1'b1, 1'b1, 4'h6, 32'h0800_0200, 8'd0);
    #1 check("burst_s1_ready_addr", s1_ar_ready, 1'b0);
    check("burst_owner_id", m_ar_id, 5'h02);
    @(posedge clock); #1;
    drive_ar(1'b0, 1'b0, 4'h0, 32'h0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1'b1; m_r_last = (i == 3); m_r_data = 32'h100 + i; m_r_id = 5'h02;
      #1 check("burst_s1_ar_ready", s1_ar_ready, 1'b0);
      check("burst_m_ar_valid", m_ar_valid, 1'b0);
      check("burst_s0_r_valid", s0_r_valid, 1'b1);
      @(posedge clock); #1;
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1 check("burst_gap_m_ar_valid", m_ar_valid, 1'b0);
    @(posedge clock); #1;
    check("burst_s1_m_ar_valid", m_ar_valid, 1'b1);
    check("burst_s1_m_ar_id", m_ar_id, 5'h16);
    check("burst_s1_ar_ready_now", s1_ar_ready, 1'b1);

    // write with W three cycles before AW on s1
    apply_reset();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    drive_w(1'b1, 1'b1, 32'h0102_0304, 4'hF);
    for (int k = 0; k < 3; k++) begin
      #1 check("wfirst_s1_w_ready", s1_w_ready, 1'b0);
      check("wfirst_m_w_valid", m_w_valid, 1'b0);
      @(posedge clock); #1;
    end
    drive_aw(1'b1, 1'b1, 4'h1, 32'h0800_0004);
    #1 check("wfirst_idle_w_ready", s1_w_ready, 1'b0);
    @(posedge clock); #1;
    check("wfirst_m_aw_id", m_aw_id, 5'h11);
    check("wfirst_m_aw_addr", m_aw_addr, 32'h0800_0004);
    check("wfirst_s1_aw_ready", s1_aw_ready, 1'b1);
    check("wfirst_s1_w_ready_gnt", s1_w_ready, 1'b1);
    check("wfirst_m_w_data", m_w_data, 32'h0102_0304);
    check("wfirst_m_w_strb", m_w_strb, 4'hF);
    @(posedge clock); #1;
    drive_aw(1'b1, 1'b0, 4'h0, 32'h0);
    drive_w(1'b1, 1'b0, 32'h0, 4'h0);
    m_b_valid = 1'b1; m_b_id = 5'h11; m_b_resp = 2'd0;
    #1 check("wfirst_resp_state", dbg_w_state, 2'd2);
    check("wfirst_s1_b_valid", s1_b_valid, 1'b1);
    check("wfirst_s1_b_id", s1_b_id, 4'h1);
    check("wfirst_s1_b_resp", s1_b_resp, 2'd0);
    check("wfirst_s0_b_valid", s0_b_valid, 1'b0);
    @(posedge clock); #1;
    m_b_valid = 1'b0;
    #1 check("wfirst_s0_b_valid_end", s0_b_valid, 1'b0);

    // independent paths: s0 read and s1 write in the same cycle
    apply_reset();
    drive_ar(1'b0, 1'b1, 4'h2, 32'h3000_0000, 8'd0);
    drive_aw(1'b1, 1'b1, 4'h4, 32'h3000_0100);
    drive_w(1'b1, 1'b1, 32'h55AA_55AA, 4'hF);
    m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    @(posedge clock); #1;
    check("indep_both_valid", {m_ar_valid, m_aw_valid, m_w_valid}, 3'b111);
    check("indep_ids", {m_ar_id, m_aw_id}, {5'h02, 5'h14});
    @(posedge clock); #1;
    drive_ar(1'b0, 1'b0, 4'h0, 32'h0, 8'd0);
    drive_aw(1'b1, 1'b0, 4'h0, 32'h0);
    drive_w(1'b1, 1'b0, 32'h0, 4'h0);
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 32'h0000_600D; m_r_id = 5'h02;
    m_b_valid = 1'b1; m_b_id = 5'h14; m_b_resp = 2'd0;
    #1 check("indep_resp_routes", {s0_r_valid, s1_r_valid, s0_b_valid, s1_b_valid}, 4'b1001);
    check("indep_b_id", s1_b_id, 4'h4);
    @(posedge clock); #1;
    m_r_valid = 1'b0; m_b_valid = 1'b0;
    #1 check("indep_both_idle", {dbg_w_state, dbg_r_state}, 4'h0);

    // reset mid-burst after an s0 read has moved rptr to s1
    apply_reset();
    run_read(vecs[0]);
    drive_ar(1'b0, 1'b1, 4'h3, 32'h0800_0300, 8'd3);
    m_ar_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    drive_ar(1'b0, 1'b0, 4'h0, 32'h0, 8'd0);
    m_r_valid = 1'b1; m_r_last = 1'b0; m_r_id = 5'h03; m_r_data = 32'h300;
    @(posedge clock); #1;
    m_r_data = 32'h301;
    s1_aw_valid = 1'b1; m_aw_ready = 1'b1;
    #1 check("rst_mid_s0_r_valid", s0_r_valid, 1'b1);
    reset = 1'b0;
    #1 check("rst_mid_all_vr", any_vr(), 1'b0);
    check("rst_mid_dbg", {dbg_w_state, dbg_r_state}, 4'h0);
    @(posedge clock); #1;
    clear_inputs();
    reset = 1'b1;
    drive_ar(1'b0, 1'b1, 4'h7, 32'h0800_0400, 8'd0);
    drive_ar(1'b1, 1'b1, 4'h8, 32'h0800_0500, 8'd0);
    m_ar_ready = 1'b1;
    @(posedge clock); #1;
    check("rst_after_grant_id", m_ar_id, 5'h07);
    check("rst_after_s0_ready", s0_ar_ready, 1'b1);
    check("rst_after_s1_ready", s1_ar_ready, 1'b0);

    clear_inputs();
    #10;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
